// File: rtl/fetch_queue.sv
// Instruction fetch front-end: reads two 16-bit RAM words per instruction,
// assembles them and queues the result for decode behind a valid/ready handshake.
module fetch_queue #(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              enb,
    output logic [ADDR_W-1:0] addrb,
    input  logic [15:0]       dob,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [7:0]        inst_op,
    output logic [7:0]        inst_reg_num,
    output logic [15:0]       inst_address_num,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ISSUE_MAX = CNT_W'(FIFO_DEPTH - 2);

    typedef enum logic [1:0] {S_IDLE, S_W0, S_W1, S_W2} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       hold;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              push, pop;

    logic [7:0]        op_mem   [FIFO_DEPTH];
    logic [7:0]        reg_mem  [FIFO_DEPTH];
    logic [15:0]       addr_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] pc_mem   [FIFO_DEPTH];

    // Space checks use the registered count only, so a same-cycle pop never
    // enables an issue; reaching S_W2 therefore always guarantees a free slot.
    always_comb begin
        state_next = state;
        enb        = 1'b0;
        addrb      = '0;
        push       = 1'b0;
        case (state)
            S_IDLE: state_next = S_W0;
            S_W0: begin
                if (count < FULL_CNT) begin
                    enb        = 1'b1;
                    addrb      = pc;
                    state_next = S_W1;
                end
            end
            S_W1: begin
                enb        = 1'b1;
                addrb      = pc + ADDR_W'(1);
                state_next = S_W2;
            end
            S_W2: begin
                push = 1'b1;
                if (count <= ISSUE_MAX) begin
                    enb        = 1'b1;
                    addrb      = pc + ADDR_W'(2);
                    state_next = S_W1;
                end else begin
                    state_next = S_W0;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign pop              = inst_valid && inst_ready;
    assign inst_valid       = (count != '0);
    assign inst_op          = op_mem[rd_ptr];
    assign inst_reg_num     = reg_mem[rd_ptr];
    assign inst_address_num = addr_mem[rd_ptr];
    assign inst_pc          = pc_mem[rd_ptr];

    // Redirect restarts in S_W0, which also discards the word still arriving on dob.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= '0;
            hold  <= '0;
        end else if (redirect) begin
            state <= S_W0;
            pc    <= redirect_pc;
        end else begin
            state <= state_next;
            if (state == S_W1) hold <= dob;
            if (push) pc <= pc + ADDR_W'(2);
        end
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                op_mem[i]   <= '0;
                reg_mem[i]  <= '0;
                addr_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                op_mem[wr_ptr]   <= hold[15:8];
                reg_mem[wr_ptr]  <= hold[7:0];
                addr_mem[wr_ptr] <= dob;
                pc_mem[wr_ptr]   <= pc;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a reset-sequence vector table plus
// hand-written sequences for fill/drain, redirects, wrap and mid-fetch reset.
module tb_fetch_queue;

    localparam int ADDR_W     = 10;
    localparam int FIFO_DEPTH = 4;

    logic              clka = 1'b0;
    logic              rst;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              enb;
    logic [ADDR_W-1:0] addrb;
    logic [15:0]       dob = 16'h0000;
    logic              inst_valid;
    logic              inst_ready;
    logic [7:0]        inst_op;
    logic [7:0]        inst_reg_num;
    logic [15:0]       inst_address_num;
    logic [ADDR_W-1:0] inst_pc;

    fetch_queue #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clka(clka), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .enb(enb), .addrb(addrb), .dob(dob),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_op(inst_op), .inst_reg_num(inst_reg_num),
        .inst_address_num(inst_address_num), .inst_pc(inst_pc)
    );

    always #5 clka = ~clka;

    // Synchronous-read RAM model for port B
    logic [15:0] ram [0:1023];
    always @(posedge clka) if (enb) dob <= ram[addrb];

    typedef struct {
        logic              rdy;
        logic              exp_enb;
        logic [ADDR_W-1:0] exp_addrb;
        logic              exp_valid;
        logic              chk_fields;
        logic [7:0]        exp_op;
        logic [7:0]        exp_reg;
        logic [15:0]       exp_addr;
        logic [ADDR_W-1:0] exp_pc;
    } vec_t;

    vec_t              vecs [9];
    int                n_cmp = 0;
    int                n_bad = 0;
    int                n_pops;
    logic [ADDR_W-1:0] exp_pc;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [ADDR_W-1:0] rpc, input logic rdy);
        redirect    = r;
        redirect_pc = rpc;
        inst_ready  = rdy;
        #1;
    endtask

    task automatic check_head(input string tag, input logic [ADDR_W-1:0] p);
        logic [ADDR_W-1:0] p1;
        p1 = p + 10'd1;
        checkOutput({tag, "_pc"},   32'(inst_pc), 32'(p));
        checkOutput({tag, "_op"},   32'(inst_op), 32'(ram[p][15:8]));
        checkOutput({tag, "_reg"},  32'(inst_reg_num), 32'(ram[p][7:0]));
        checkOutput({tag, "_addr"}, 32'(inst_address_num), 32'(ram[p1]));
    endtask

    task automatic check_pop();
        if (inst_valid && inst_ready) begin
            check_head("pop", exp_pc);
            exp_pc = exp_pc + 10'd2;
            n_pops++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_enb"},   32'(enb), 32'd0);
        checkOutput({tag, "_addrb"}, 32'(addrb), 32'd0);
        checkOutput({tag, "_valid"}, 32'(inst_valid), 32'd0);
        checkOutput({tag, "_fields"}, {inst_op, inst_reg_num, inst_address_num}, 32'd0);
        checkOutput({tag, "_ipc"},   32'(inst_pc), 32'd0);
    endtask

    // Returns at the negedge where rst falls; the next posedge is E0.
    task automatic do_reset();
        @(negedge clka);
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        check_reset_outputs("rst");
        repeat (2) @(negedge clka);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] last_addr, first_addr;
        logic              seen;

        for (int i = 0; i < 1024; i++) ram[i] = 16'hC000 | 16'(i);
        ram[0] = 16'h0405;
        ram[1] = 16'h1234;
        rst = 1'b1;
        redirect = 1'b0;
        redirect_pc = '0;
        inst_ready = 1'b0;

        // Reset sequence with ready held high: rdy, enb, addrb, valid, chk, op, reg, addr, pc
        vecs[0] = '{1'b1, 1'b0, 10'd0, 1'b0, 1'b1, 8'h00, 8'h00, 16'h0000, 10'd0};
        vecs[1] = '{1'b1, 1'b1, 10'd0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 10'd0};
        vecs[2] = '{1'b1, 1'b1, 10'd1, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 10'd0};
        vecs[3] = '{1'b1, 1'b1, 10'd2, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 10'd0};
        vecs[4] = '{1'b1, 1'b1, 10'd3, 1'b1, 1'b1, 8'h04, 8'h05, 16'h1234, 10'd0};
        vecs[5] = '{1'b1, 1'b1, 10'd4, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 10'd0};
        vecs[6] = '{1'b1, 1'b1, 10'd5, 1'b1, 1'b1, 8'hC0, 8'h02, 16'hC003, 10'd2};
        vecs[7] = '{1'b1, 1'b1, 10'd6, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 10'd0};
        vecs[8] = '{1'b1, 1'b1, 10'd7, 1'b1, 1'b1, 8'hC0, 8'h04, 16'hC005, 10'd4};

        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i != 0) @(negedge clka);
            applyStimulus(1'b0, '0, vecs[i].rdy);
            checkOutput($sformatf("vec%0d_enb", i),   32'(enb),   32'(vecs[i].exp_enb));
            checkOutput($sformatf("vec%0d_addrb", i), 32'(addrb), 32'(vecs[i].exp_addrb));
            checkOutput($sformatf("vec%0d_valid", i), 32'(inst_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].chk_fields) begin
                checkOutput($sformatf("vec%0d_op", i),   32'(inst_op), 32'(vecs[i].exp_op));
                checkOutput($sformatf("vec%0d_reg", i),  32'(inst_reg_num), 32'(vecs[i].exp_reg));
                checkOutput($sformatf("vec%0d_addr", i), 32'(inst_address_num), 32'(vecs[i].exp_addr));
                checkOutput($sformatf("vec%0d_pc", i),   32'(inst_pc), 32'(vecs[i].exp_pc));
            end
        end

        // Fill with ready low, then drain and check ordering and resume address
        do_reset();
        applyStimulus(1'b0, '0, 1'b0);
        last_addr = '0;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clka);
            applyStimulus(1'b0, '0, 1'b0);
            if (enb) last_addr = addrb;
        end
        checkOutput("full_enb", 32'(enb), 32'd0);
        checkOutput("full_last_req", 32'(last_addr), 32'd7);
        checkOutput("full_valid", 32'(inst_valid), 32'd1);
        check_head("full_head", 10'd0);
        exp_pc = '0;
        n_pops = 0;
        seen = 1'b0;
        first_addr = '0;
        for (int c = 14; c <= 33; c++) begin
            @(negedge clka);
            applyStimulus(1'b0, '0, 1'b1);
            if (enb && !seen) begin
                first_addr = addrb;
                seen = 1'b1;
            end
            check_pop();
        end
        checkOutput("drain_resume_addr", 32'(first_addr), 32'd8);
        checkOutput("drain_pops", 32'(n_pops), 32'd12);

        // Redirect to 0x100 while word 1 of pc 6 is in flight, 2 entries queued
        do_reset();
        applyStimulus(1'b0, '0, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clka);
            applyStimulus(1'b0, '0, (c == 4));
        end
        @(negedge clka);
        applyStimulus(1'b1, 10'h100, 1'b0);
        checkOutput("redir_inflight_addrb", 32'(addrb), 32'd7);
        @(negedge clka);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("redir_valid_drop", 32'(inst_valid), 32'd0);
        checkOutput("redir_req_enb", 32'(enb), 32'd1);
        checkOutput("redir_req_addrb", 32'(addrb), 32'h100);
        exp_pc = 10'h100;
        n_pops = 0;
        for (int c = 10; c <= 20; c++) begin
            @(negedge clka);
            applyStimulus(1'b0, '0, 1'b1);
            check_pop();
        end
        checkOutput("redir_pops", 32'(n_pops), 32'd5);

        // Redirect to the top of the address space: word 1 wraps to 0
        @(negedge clka);
        applyStimulus(1'b1, 10'h3FF, 1'b0);
        @(negedge clka);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("wrap_valid", 32'(inst_valid), 32'd0);
        checkOutput("wrap_req0", 32'(addrb), 32'h3FF);
        @(negedge clka);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("wrap_req1", 32'(addrb), 32'h000);
        @(negedge clka);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("wrap_next_fetch", 32'(addrb), 32'h001);
        @(negedge clka);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("wrap_head_valid", 32'(inst_valid), 32'd1);
        check_head("wrap_head", 10'h3FF);
        checkOutput("wrap_head_addrnum", 32'(inst_address_num), 32'h0405);

        // Redirect and pop in the same cycle with three entries queued
        do_reset();
        applyStimulus(1'b0, '0, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clka);
            applyStimulus(1'b0, '0, 1'b0);
        end
        @(negedge clka);
        applyStimulus(1'b1, 10'h040, 1'b1);
        checkOutput("rp_pre_valid", 32'(inst_valid), 32'd1);
        for (int c = 9; c <= 11; c++) begin
            @(negedge clka);
            applyStimulus(1'b0, '0, 1'b0);
            checkOutput($sformatf("rp_empty_c%0d", c), 32'(inst_valid), 32'd0);
        end
        @(negedge clka);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("rp_new_valid", 32'(inst_valid), 32'd1);
        check_head("rp_new_head", 10'h040);
        exp_pc = 10'h040;
        n_pops = 0;
        for (int c = 13; c <= 18; c++) begin
            @(negedge clka);
            applyStimulus(1'b0, '0, 1'b1);
            check_pop();
        end
        checkOutput("rp_pops", 32'(n_pops), 32'd4);

        // Reset asserted mid-fetch while in S_W1
        do_reset();
        applyStimulus(1'b0, '0, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clka);
            applyStimulus(1'b0, '0, 1'b0);
        end
        checkOutput("mid_w1_addrb", 32'(addrb), 32'd5);
        checkOutput("mid_w1_valid", 32'(inst_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clka);
        rst = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clka);
            applyStimulus(1'b0, '0, 1'b0);
            if (c == 1) checkOutput("restart_req0", 32'(addrb), 32'd0);
            if (c == 2) checkOutput("restart_req1", 32'(addrb), 32'd1);
            if (c == 3) checkOutput("restart_not_yet", 32'(inst_valid), 32'd0);
        end
        checkOutput("restart_valid", 32'(inst_valid), 32'd1);
        check_head("restart_head", 10'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
